// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared types and constants for the histogram top-k engine
//
// Holds the engine state enum, the count-width derivation and the length of
// the pipeline drain phase. Imported by hist_topk_engine and its sub-modules.
package hist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READ    = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    // One extra bit over the frame address so a count of LENGTH fits.
    function automatic int cnt_width(input int length_size);
        return length_size + 1;
    endfunction

    // Cycles spent in FLUSH so the read/sum/insert pipelines drain.
    localparam int FLUSH_CYCLES = 3;

endpackage

// File: rtl/hist_topk_sorter.sv
// rtl/hist_topk_sorter.sv - TOP_K insertion chain ranking (bin, count) pairs
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               synchronous clear of every slot
//   in_valid          an incoming (in_data, in_count) pair is offered
//   in_data/in_count  bin value and its count
//   out_data/out_count ranked slots, rank 0 in the LSBs
module hist_topk_sorter #(
    parameter int TOP_K     = 3,
    parameter int DATA_SIZE = 4,
    parameter int CNT_W     = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [DATA_SIZE-1:0]       in_data,
    input  logic [CNT_W-1:0]           in_count,
    output logic [TOP_K*DATA_SIZE-1:0] out_data,
    output logic [TOP_K*CNT_W-1:0]     out_count
);

    logic [DATA_SIZE-1:0] slot_data_q [TOP_K];
    logic [DATA_SIZE-1:0] slot_data_d [TOP_K];
    logic [CNT_W-1:0]     slot_cnt_q  [TOP_K];
    logic [CNT_W-1:0]     slot_cnt_d  [TOP_K];
    logic                 prev_gt;
    logic                 cur_gt;
    logic [DATA_SIZE-1:0] carry_data;
    logic [CNT_W-1:0]     carry_cnt;

    // Slots stay sorted non-increasing, so "in_count > slot" is monotone down
    // the chain: the first slot that loses takes the new pair, every slot
    // after it takes its predecessor. Strict compare keeps earlier bins ahead
    // on ties, and a zero count can never win.
    always_comb begin
        slot_data_d = slot_data_q;
        slot_cnt_d  = slot_cnt_q;
        prev_gt     = 1'b0;
        cur_gt      = 1'b0;
        carry_data  = '0;
        carry_cnt   = '0;
        for (int j = 0; j < TOP_K; j++) begin
            cur_gt = in_count > slot_cnt_q[j];
            if (clr) begin
                slot_data_d[j] = '0;
                slot_cnt_d[j]  = '0;
            end else if (in_valid) begin
                if (prev_gt) begin
                    slot_data_d[j] = carry_data;
                    slot_cnt_d[j]  = carry_cnt;
                end else if (cur_gt) begin
                    slot_data_d[j] = in_data;
                    slot_cnt_d[j]  = in_count;
                end
            end
            carry_data = slot_data_q[j];
            carry_cnt  = slot_cnt_q[j];
            prev_gt    = cur_gt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < TOP_K; j++) begin
                slot_data_q[j] <= '0;
                slot_cnt_q[j]  <= '0;
            end
        end else begin
            slot_data_q <= slot_data_d;
            slot_cnt_q  <= slot_cnt_d;
        end
    end

    always_comb begin
        out_data  = '0;
        out_count = '0;
        for (int j = 0; j < TOP_K; j++) begin
            out_data[j*DATA_SIZE +: DATA_SIZE] = slot_data_q[j];
            out_count[j*CNT_W +: CNT_W]        = slot_cnt_q[j];
        end
    end

endmodule

// File: rtl/hist_topk_engine.sv
// rtl/hist_topk_engine.sv - banked frame histogram with replay and top-k ranking
//
// Collects LENGTH samples round-robin into CHANNELS histogram banks, then
// replays the frame and ranks the TOP_K most frequent bins.
// Build option HTE_FRAME_OUT_EN: when defined, frame storage and the replay
// pipeline are built; otherwise fram_* are tied to 0 and READ covers only the
// DATA_NUM histogram bins.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a frame (honoured in IDLE only)
//   in_valid/in_data    sample input, accepted while in_ready is high
//   in_ready, busy      COLLECT / not-IDLE status
//   fram_en/add/data    replayed frame sample stream
//   sort_valid          one-cycle pulse when max_data/max_count are final
//   max_data/max_count  ranked bins and counts, rank 0 in the LSBs
module hist_topk_engine
    import hist_pkg::*;
#(
    parameter  int DATA_SIZE   = 4,
    parameter  int LENGTH      = 64,
    parameter  int LENGTH_SIZE = 6,
    parameter  int CHANNELS    = 4,
    parameter  int TOP_K       = 3,
    localparam int CNT_W       = cnt_width(LENGTH_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_SIZE-1:0]       in_data,
    output logic                       in_ready,
    output logic                       busy,
    output logic                       fram_en,
    output logic [LENGTH_SIZE-1:0]     fram_add,
    output logic [DATA_SIZE-1:0]       fram_data,
    output logic                       sort_valid,
    output logic [TOP_K*DATA_SIZE-1:0] max_data,
    output logic [TOP_K*CNT_W-1:0]     max_count
);

    localparam int DATA_NUM = 1 << DATA_SIZE;
`ifdef HTE_FRAME_OUT_EN
    localparam int READ_LEN = LENGTH;
`else
    localparam int READ_LEN = DATA_NUM;
`endif

    state_t                 state_q, state_d;
    logic [LENGTH_SIZE-1:0] wr_cnt_q, wr_cnt_d, rd_idx_q, rd_idx_d;
    logic [1:0]             flush_cnt_q, flush_cnt_d;
    logic                   accept, clear, rd_issue, hist_issue, last_bin;

    logic [CNT_W-1:0]       hist_q [CHANNELS][DATA_NUM];
    logic [CNT_W-1:0]       hist_d [CHANNELS][DATA_NUM];
    logic [CNT_W-1:0]       hrd_q  [CHANNELS];
    logic [CNT_W-1:0]       hrd_d  [CHANNELS];
    logic                   hvld_q, hvld_d, hlast_q, hlast_d;
    logic [DATA_SIZE-1:0]   hbin_q, hbin_d, sum_bin_q, sum_bin_d;
    logic [CNT_W-1:0]       sum_q, sum_d;
    logic                   sum_vld_q, sum_vld_d, sum_last_q, sum_last_d;
    logic                   ins_last_q, ins_last_d, sort_valid_q, sort_valid_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_COLLECT;
            ST_COLLECT: if (accept && 32'(wr_cnt_q) == LENGTH - 1) state_d = ST_READ;
            ST_READ:    if (32'(rd_idx_q) == READ_LEN - 1) state_d = ST_FLUSH;
            ST_FLUSH:   if (32'(flush_cnt_q) == FLUSH_CYCLES - 1) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_COLLECT);
        busy       = (state_q != ST_IDLE);
        clear      = (state_q == ST_IDLE) && start;
        accept     = in_ready && in_valid;
        rd_issue   = (state_q == ST_READ);
        hist_issue = rd_issue && (32'(rd_idx_q) < DATA_NUM);
        last_bin   = rd_issue && (32'(rd_idx_q) == DATA_NUM - 1);
    end

    always_comb begin
        wr_cnt_d    = clear ? '0 : (accept ? wr_cnt_q + 1'b1 : wr_cnt_q);
        rd_idx_d    = (rd_issue && state_d == ST_READ) ? rd_idx_q + 1'b1 : '0;
        flush_cnt_d = (state_q == ST_FLUSH) ? flush_cnt_q + 1'b1 : '0;

        // Banks are flop arrays updated in place, so consecutive hits on the
        // same bin (only possible with one bank) accumulate without forwarding.
        hist_d = hist_q;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < DATA_NUM; b++) begin
                if (clear) hist_d[c][b] = '0;
            end
            if (accept && (32'(wr_cnt_q) % CHANNELS) == c)
                hist_d[c][in_data] = hist_q[c][in_data] + 1'b1;
        end

        // Read stage, then full-width sum stage; the total never exceeds LENGTH.
        hvld_d  = hist_issue;
        hlast_d = last_bin;
        hbin_d  = rd_idx_q[DATA_SIZE-1:0];
        sum_d   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hrd_d[c] = hist_q[c][rd_idx_q[DATA_SIZE-1:0]];
            sum_d    = sum_d + hrd_q[c];
        end
        sum_vld_d    = hvld_q;
        sum_bin_d    = hbin_q;
        sum_last_d   = hlast_q;
        ins_last_d   = sum_last_q;
        sort_valid_d = ins_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q     <= '0;
            rd_idx_q     <= '0;
            flush_cnt_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hrd_q[c] <= '0;
                for (int b = 0; b < DATA_NUM; b++) hist_q[c][b] <= '0;
            end
            hvld_q       <= 1'b0;
            hlast_q      <= 1'b0;
            hbin_q       <= '0;
            sum_q        <= '0;
            sum_vld_q    <= 1'b0;
            sum_bin_q    <= '0;
            sum_last_q   <= 1'b0;
            ins_last_q   <= 1'b0;
            sort_valid_q <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_idx_q     <= rd_idx_d;
            flush_cnt_q  <= flush_cnt_d;
            hist_q       <= hist_d;
            hrd_q        <= hrd_d;
            hvld_q       <= hvld_d;
            hlast_q      <= hlast_d;
            hbin_q       <= hbin_d;
            sum_q        <= sum_d;
            sum_vld_q    <= sum_vld_d;
            sum_bin_q    <= sum_bin_d;
            sum_last_q   <= sum_last_d;
            ins_last_q   <= ins_last_d;
            sort_valid_q <= sort_valid_d;
        end
    end

    assign sort_valid = sort_valid_q;

    hist_topk_sorter #(
        .TOP_K     (TOP_K),
        .DATA_SIZE (DATA_SIZE),
        .CNT_W     (CNT_W)
    ) u_sorter (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear),
        .in_valid  (sum_vld_q),
        .in_data   (sum_bin_q),
        .in_count  (sum_q),
        .out_data  (max_data),
        .out_count (max_count)
    );

`ifdef HTE_FRAME_OUT_EN
    localparam int WORDS      = LENGTH / CHANNELS;
    localparam int WORD_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BANK_SHIFT = $clog2(CHANNELS);

    logic [WORD_W-1:0]             wr_word, rd_word;
    logic [CHANNELS*DATA_SIZE-1:0] ram_rdata;
    logic                          fen1_q, fen1_d, fram_en_q, fram_en_d;
    logic [LENGTH_SIZE-1:0]        fadd1_q, fadd1_d, fram_add_q, fram_add_d;
    logic [DATA_SIZE-1:0]          fram_data_q, fram_data_d;

    assign wr_word = WORD_W'(wr_cnt_q >> BANK_SHIFT);
    assign rd_word = WORD_W'(rd_idx_q >> BANK_SHIFT);

    // Sample n lives in bank n mod CHANNELS at word n / CHANNELS.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_frame_bank
        logic [DATA_SIZE-1:0] frame_mem [WORDS];
        logic [DATA_SIZE-1:0] rdata;
        always_ff @(posedge clk) begin
            if (accept && (32'(wr_cnt_q) % CHANNELS) == c) frame_mem[wr_word] <= in_data;
            rdata <= frame_mem[rd_word];
        end
        assign ram_rdata[c*DATA_SIZE +: DATA_SIZE] = rdata;
    end

    always_comb begin
        fen1_d      = rd_issue;
        fadd1_d     = rd_idx_q;
        fram_en_d   = fen1_q;
        fram_add_d  = fram_add_q;
        fram_data_d = fram_data_q;
        if (clear) begin
            fram_add_d  = '0;
            fram_data_d = '0;
        end else if (fen1_q) begin
            fram_add_d = fadd1_q;
            for (int c = 0; c < CHANNELS; c++) begin
                if ((32'(fadd1_q) % CHANNELS) == c)
                    fram_data_d = ram_rdata[c*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fen1_q      <= 1'b0;
            fadd1_q     <= '0;
            fram_en_q   <= 1'b0;
            fram_add_q  <= '0;
            fram_data_q <= '0;
        end else begin
            fen1_q      <= fen1_d;
            fadd1_q     <= fadd1_d;
            fram_en_q   <= fram_en_d;
            fram_add_q  <= fram_add_d;
            fram_data_q <= fram_data_d;
        end
    end

    assign fram_en   = fram_en_q;
    assign fram_add  = fram_add_q;
    assign fram_data = fram_data_q;
`else
    assign fram_en   = 1'b0;
    assign fram_add  = '0;
    assign fram_data = '0;
`endif

endmodule

// File: tb/tb_hist_topk_engine.sv
// tb/tb_hist_topk_engine.sv - self-checking scoreboard bench for hist_topk_engine
module tb_hist_topk_engine;

    localparam int LENGTH   = 64;
    localparam int SORT_LAT = 84;
`ifdef HTE_FRAME_OUT_EN
    localparam int READ_LEN = 64;
    localparam int EXP_FEN  = 64;
`else
    localparam int READ_LEN = 16;
    localparam int EXP_FEN  = 0;
`endif
    localparam int EXP_BUSY = LENGTH + READ_LEN + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = 4'd0;
    logic        in_ready, busy, fram_en, sort_valid;
    logic [5:0]  fram_add;
    logic [3:0]  fram_data;
    logic [11:0] max_data;
    logic [20:0] max_count;

    hist_topk_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .fram_en    (fram_en),
        .fram_add   (fram_add),
        .fram_data  (fram_data),
        .sort_valid (sort_valid),
        .max_data   (max_data),
        .max_count  (max_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [3:0]  samp [LENGTH];
    logic [11:0] q_data [$];
    logic [20:0] q_cnt  [$];
    logic [5:0]  q_add  [$];
    logic [3:0]  q_fd   [$];
    logic [11:0] last_data;
    logic [20:0] last_cnt;
    bit          mon_en = 1'b0;
    int          start_cyc, sv_cyc, sv_cnt, fen_cnt, fen_first, busy_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_fram_en"},    fram_en,    0);
        check({tag, "_sort_valid"}, sort_valid, 0);
        check({tag, "_fram_add"},   fram_add,   0);
        check({tag, "_fram_data"},  fram_data,  0);
        check({tag, "_max_data"},   max_data,   0);
        check({tag, "_max_count"},  max_count,  0);
    endtask

    task automatic build(input int pat);
        for (int n = 0; n < LENGTH; n++) begin
            case (pat)
                0: samp[n] = 4'd5;
                1: samp[n] = 4'(n % 16);
                2: samp[n] = (n < 30) ? 4'd3 : (n < 50) ? 4'd9 : (n < 60) ? 4'd1 : 4'd15;
                default: samp[n] = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    // Reference ranking: repeated selection of the largest nonzero count,
    // lowest bin winning ties.
    task automatic push_expect();
        int cnt [16];
        bit used [16];
        int best;
        for (int b = 0; b < 16; b++) begin
            cnt[b]  = 0;
            used[b] = 1'b0;
        end
        for (int n = 0; n < LENGTH; n++) cnt[samp[n]]++;
        last_data = '0;
        last_cnt  = '0;
        for (int k = 0; k < 3; k++) begin
            best = -1;
            for (int b = 0; b < 16; b++)
                if (!used[b] && cnt[b] > 0 && (best < 0 || cnt[b] > cnt[best])) best = b;
            if (best >= 0) begin
                used[best] = 1'b1;
                last_data[k*4 +: 4] = 4'(best);
                last_cnt[k*7 +: 7]  = 7'(cnt[best]);
            end
        end
        q_data.push_back(last_data);
        q_cnt.push_back(last_cnt);
`ifdef HTE_FRAME_OUT_EN
        for (int n = 0; n < LENGTH; n++) begin
            q_add.push_back(6'(n));
            q_fd.push_back(samp[n]);
        end
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (fram_en) begin
                if (fen_cnt == 0) fen_first = cyc;
                fen_cnt++;
                check("fram_expected", 32'(q_add.size() != 0), 1);
                if (q_add.size() != 0) begin
                    check("fram_add",  fram_add,  q_add.pop_front());
                    check("fram_data", fram_data, q_fd.pop_front());
                end
            end
            if (sort_valid) begin
                sv_cnt++;
                sv_cyc = cyc;
                check("sort_expected", 32'(q_data.size() != 0), 1);
                if (q_data.size() != 0) begin
                    check("max_data",  max_data,  q_data.pop_front());
                    check("max_count", max_count, q_cnt.pop_front());
                end
            end
        end
    end

    task automatic run_frame(input bit gappy, input bit abort);
        int  idx;
        int  guard;
        bit  v;
        bit  acc;
        if (!abort) push_expect();
        sv_cnt = 0; fen_cnt = 0; busy_cnt = 0; fen_first = 0; sv_cyc = 0;
        mon_en = !abort;
        @(negedge clk);
        check("in_ready_idle", in_ready, 0);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_rise", in_ready, 1);
        idx = 0;
        guard = 0;
        while (idx < LENGTH && guard < 1000) begin
            v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data  = samp[idx];
            start    = gappy && ($urandom_range(0, 5) == 0);
            acc      = v && in_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        check("accepted_samples", idx, LENGTH);
        check("in_ready_fall", in_ready, 0);
        if (!abort) begin
            guard = 0;
            while (busy && guard < 400) begin
                @(negedge clk);
                guard++;
            end
            in_valid = 1'b0;
            repeat (6) @(negedge clk);
            check("busy_done", busy, 0);
            check("sort_pulses", sv_cnt, 1);
            check("fram_cycles", fen_cnt, EXP_FEN);
            check("hold_data", max_data, last_data);
            check("hold_count", max_count, last_cnt);
            check("queues_drained", q_data.size() + q_add.size(), 0);
            if (!gappy) begin
                check("busy_cycles", busy_cnt, EXP_BUSY);
                check("sort_latency", sv_cyc - start_cyc, SORT_LAT);
`ifdef HTE_FRAME_OUT_EN
                check("fram_latency", fen_first - start_cyc, 67);
`endif
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        build(0); run_frame(1'b0, 1'b0);
        build(1); run_frame(1'b0, 1'b0);
        build(2); run_frame(1'b0, 1'b0);
        build(3); run_frame(1'b1, 1'b0);

        build(2); run_frame(1'b0, 1'b1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        build(2); run_frame(1'b0, 1'b0);
        build(1); run_frame(1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hist_topk_engine.md
# hist_topk_engine

Single-clock, parametrised successor to the two-clock histogram/top-3 capture path. The block accepts one frame of `LENGTH` samples over a valid/ready handshake and distributes them round-robin across `CHANNELS` histogram banks. It then replays the captured frame and ranks the `TOP_K` most frequent values. It sits directly behind the sample source in the `clk` domain; no CDC FIFO is needed.

## Interface
Parameters:
- `DATA_SIZE`, 4: sample width in bits. There are `DATA_NUM` = 2^`DATA_SIZE` bins.
- `LENGTH`, 64: samples per frame. Must be a multiple of `CHANNELS` and must be ≥ `DATA_NUM`.
- `LENGTH_SIZE`, 6: frame address width, equal to clog2(`LENGTH`).
- `CHANNELS`, 4: number of histogram banks. Must be a power of two, from 1 to 8.
- `TOP_K`, 3: number of ranked outputs, from 1 to `DATA_NUM`.

Ports. Clocking is one clock; reset is synchronous and active-high.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a new frame. Honoured only in IDLE.
- `in_valid` in 1: a sample is present on `in_data`.
- `in_data` in `DATA_SIZE`: sample value.
- `in_ready` out 1: high exactly while in COLLECT.
- `busy` out 1: high whenever the state is not IDLE.
- `fram_en` out 1: frame replay data is valid.
- `fram_add` out `LENGTH_SIZE`: replay address.
- `fram_data` out `DATA_SIZE`: replayed sample.
- `sort_valid` out 1: one-cycle pulse when the rank outputs are final.
- `max_data` out `TOP_K*DATA_SIZE`: ranked bin values. Rank 0 is in the LSBs.
- `max_count` out `TOP_K*CNT_W`: ranked counts. `CNT_W` = `LENGTH_SIZE`+1, so a count of `LENGTH` is representable.

## Operation
State machine: IDLE → COLLECT → READ → FLUSH → IDLE.

- **IDLE**
  - On `start`, all bank histograms and all rank registers are cleared, and the state moves to COLLECT.
- **COLLECT**
  - A sample is accepted when `in_valid && in_ready`.
  - Accepted sample n (0-based) is written to frame address n in bank n mod `CHANNELS`, at bank word n/`CHANNELS`.
  - The bin `in_data` of that bank is incremented.
  - After sample `LENGTH`-1 is accepted, the state moves to READ on the next cycle.
  - A `start` during COLLECT is ignored.
- **READ**
  - The read index r steps from 0 to `LENGTH`-1, one step per cycle.
  - Each r issues a frame read of bank r mod `CHANNELS`.
  - For r < `DATA_NUM`, each r also issues a histogram read of bin r from all banks. The bank outputs are summed at full `CNT_W` width with no saturation, which is possible because the total is ≤ `LENGTH`.
- **FLUSH**
  - Lasts 3 cycles to drain the pipelines. The state then moves to IDLE.
- **Top-K insertion**
  - The ranks form a chain of `TOP_K` slots.
  - An incoming (bin, count) pair displaces slot j only if its count is strictly greater than the count in slot j. Lower slots shift down and the last slot drops out.
  - Ties keep the earlier, lower-numbered bin at the higher rank.
  - Bins with a count of 0 never enter. Unfilled slots read data 0, count 0.
- **Result lifetime**
  - The rank outputs and the last replay values hold until the next accepted `start`.
- **Reset**
  - A reset asserted mid-operation returns the block to IDLE.
  - It zeroes every output, histogram and rank register.
  - Frame memory contents are don't-care after reset.

## Timing
- Reset values:
  - `in_ready`, `busy`, `fram_en`, `sort_valid` = 0.
  - `fram_add`, `fram_data`, `max_data`, `max_count` = 0.
- `in_ready` rises the cycle after `start` is sampled in IDLE.
- `in_ready` falls the cycle after the final sample is accepted.
- A histogram update is visible one cycle after its sample is accepted. Back-to-back same-value samples to the same bank are impossible with `CHANNELS` ≥ 2. For `CHANNELS` = 1, the increment must forward the previous update.
- Frame replay latency is 2 cycles. `fram_en`, `fram_add` = r and `fram_data` appear 2 cycles after index r is issued. `fram_en` is therefore high for exactly `LENGTH` contiguous cycles.
- Histogram sum latency is 2 cycles, and insertion takes 1 more cycle.
- `sort_valid` pulses 4 cycles after bin `DATA_NUM`-1 is issued. It pulses once per frame.
- Frame period = 1 + `LENGTH` (collect, with `in_valid` held high) + `LENGTH` + 3 cycles.

## Configuration
- `HTE_FRAME_OUT_EN` defined: frame storage and the replay pipeline are built, and the behaviour is as above.
- `HTE_FRAME_OUT_EN` undefined: no frame memory is built, and `fram_en`, `fram_add`, `fram_data` are tied to 0.
  - READ runs only `DATA_NUM` cycles.
  - `sort_valid` timing relative to bin issue is unchanged.

## Structure
- Package `hist_pkg` holds:
  - the state enum (IDLE, COLLECT, READ, FLUSH);
  - the `CNT_W` derivation function;
  - the FLUSH length constant.
- Sub-module `hist_topk_sorter` holds the `TOP_K` insertion chain. It is parametrised by `TOP_K`, `DATA_SIZE` and `CNT_W`, and has a synchronous clear input.
- The banks are a generate loop inside the top level.

## Test plan
- **Frame of all 5s.** Stimulus: `start`, then 64 samples of value 5 with `in_valid` held high. Response: rank0 = (5, 64), rank1 = (0, 0), rank2 = (0, 0). `sort_valid` pulses once.
- **Ramp.** Stimulus: samples n mod 16, for n = 0..63. Response: every bin has count 4. Ties resolve to ranks (0, 4), (1, 4), (2, 4). Replay gives `fram_add` = n with `fram_data` = n mod 16 for 64 contiguous cycles.
- **Mixed frame.** Stimulus: 30×value 3, 20×value 9, 10×value 1, 4×value 15. Response: the ranks are (3, 30), (9, 20), (1, 10).
- **Gappy handshake.** Stimulus: `in_valid` toggled randomly, with `start` pulsed during COLLECT. Response: exactly 64 samples are accepted, the extra `start` has no effect, and the results match the reference model.
- **Reset mid-operation.** Stimulus: `rst` asserted in the middle of READ. Response: the next cycle shows all outputs 0 and `busy` = 0. A following frame then produces correct results.
- **Config off.** Stimulus: `HTE_FRAME_OUT_EN` undefined, mixed frame. Response: `fram_en` stays 0, the ranks are identical to the mixed-frame case, and `busy` falls after 1 + 64 + 16 + 3 cycles.
